// File: rtl/csr_seq_pkg.sv
// csr_seq_pkg: shared encodings for the CSR/trap sequencer.
// Holds instruction op codes, the sequencer state enum, trap cause values
// and the machine-mode CSR addresses the sequencer deals with.
package csr_seq_pkg;

    localparam logic [2:0] OP_CSRRW = 3'd1;
    localparam logic [2:0] OP_CSRRS = 3'd2;
    localparam logic [2:0] OP_CSRRC = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_TRAP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // mcause values: environment call from M-mode, machine timer interrupt
    localparam logic [63:0] CAUSE_ECALL_M     = 64'd11;
    localparam logic [63:0] CAUSE_TIMER_INT_M = 64'h8000_0000_0000_0007;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    function automatic logic is_csr_op(input logic [2:0] op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

endpackage

// File: rtl/csr_alu.sv
// csr_alu: read-modify-write value for CSRRW/CSRRS/CSRRC and the flag that
// cancels the write for set/clear forms whose source register/uimm is x0/0.
module csr_alu
    import csr_seq_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [63:0] old,
    input  logic [63:0] src,
    input  logic        src_zero,
    output logic [63:0] new_val,
    output logic        suppress
);

    // new CSR value and write-cancel flag, full 64-bit
    always_comb begin
        new_val  = src;
        suppress = 1'b0;
        case (op)
            OP_CSRRS: begin
                new_val  = old | src;
                suppress = src_zero;
            end
            OP_CSRRC: begin
                new_val  = old & ~src;
                suppress = src_zero;
            end
            default: begin
                new_val  = src;
                suppress = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_seq.sv
// csr_seq: sequences CSR read-modify-write, ECALL and MRET against an
// external CSR file and returns the result / redirect to the pipeline.
// Optional timer-interrupt entry from IDLE is compiled in by defining
// CSR_SEQ_TINT_EN; without it tint and resume_pc are ignored.
//
// state | meaning
// IDLE  | waiting for an instruction (or interrupt when enabled)
// READ  | csr_re strobe, old CSR value captured
// WRITE | csr_we strobe with the computed value (may be cancelled)
// TRAP  | ecall or mret strobe, trap target captured from csr_rdata
// DONE  | result presented on out_valid until out_ready
module csr_seq
    import csr_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [11:0] csr_addr,
    input  logic [63:0] src,
    input  logic        src_zero,
    input  logic [63:0] pc,
    input  logic [63:0] resume_pc,
    output logic [11:0] csr_id,
    output logic        csr_re,
    output logic        csr_we,
    output logic [63:0] csr_wdata,
    output logic        ecall,
    output logic        mret,
    output logic [63:0] epc,
    input  logic [63:0] csr_rdata,
    input  logic        tint,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] rd_data,
    output logic        redirect,
    output logic [63:0] redirect_pc
);

    state_e      state;
    state_e      state_nx;
    logic [2:0]  op_q;
    logic [11:0] addr_q;
    logic [63:0] src_q;
    logic        src_zero_q;
    logic [63:0] pc_q;
    logic [63:0] rd_q;
    logic [63:0] redir_pc_q;
    logic        redir_q;
    logic [63:0] alu_val;
    logic        alu_suppress;
    logic        accept;
    logic        take_int;

`ifdef CSR_SEQ_TINT_EN
    assign take_int = rst && (state == ST_IDLE) && tint;
`else
    logic unused_int_inputs;
    assign unused_int_inputs = ^{tint, resume_pc};
    assign take_int = 1'b0;
`endif

    // an interrupt in IDLE blocks acceptance of the offered instruction
    assign in_ready = rst && (state == ST_IDLE) && !take_int;
    assign accept   = in_valid && in_ready;

    csr_alu u_alu (
        .op       (op_q),
        .old      (rd_q),
        .src      (src_q),
        .src_zero (src_zero_q),
        .new_val  (alu_val),
        .suppress (alu_suppress)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // instruction latch, old value capture and trap target capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            pc_q       <= '0;
            rd_q       <= '0;
            redir_pc_q <= '0;
            redir_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= op;
                addr_q     <= csr_addr;
                src_q      <= src;
                src_zero_q <= src_zero;
                pc_q       <= pc;
                rd_q       <= '0;
                redir_pc_q <= '0;
                redir_q    <= 1'b0;
            end
            if (take_int) begin
                rd_q       <= '0;
                redir_pc_q <= csr_rdata;
                redir_q    <= 1'b1;
            end
            if (state == ST_READ) rd_q <= csr_rdata;
            if (state == ST_TRAP) begin
                redir_pc_q <= csr_rdata;
                redir_q    <= 1'b1;
            end
        end
    end

    // next state and state-decoded outputs; everything forced low in reset
    always_comb begin
        state_nx    = state;
        csr_id      = '0;
        csr_re      = 1'b0;
        csr_we      = 1'b0;
        csr_wdata   = '0;
        ecall       = 1'b0;
        mret        = 1'b0;
        epc         = '0;
        out_valid   = 1'b0;
        rd_data     = '0;
        redirect    = 1'b0;
        redirect_pc = '0;

        case (state)
            ST_IDLE: begin
                if (take_int)                              state_nx = ST_DONE;
                else if (accept && is_csr_op(op))          state_nx = ST_READ;
                else if (accept && (op == OP_ECALL || op == OP_MRET)) state_nx = ST_TRAP;
                else if (accept)                           state_nx = ST_DONE;
            end
            ST_READ:  state_nx = ST_WRITE;
            ST_WRITE: state_nx = ST_DONE;
            ST_TRAP:  state_nx = ST_DONE;
            ST_DONE:  if (out_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase

        if (rst) begin
            case (state)
`ifdef CSR_SEQ_TINT_EN
                ST_IDLE: begin
                    if (take_int) begin
                        epc       = resume_pc;
                        csr_wdata = CAUSE_TIMER_INT_M;
                    end
                end
`endif
                ST_READ: begin
                    csr_id = addr_q;
                    csr_re = 1'b1;
                end
                ST_WRITE: begin
                    csr_id    = addr_q;
                    csr_we    = !alu_suppress;
                    csr_wdata = alu_val;
                end
                ST_TRAP: begin
                    if (op_q == OP_ECALL) begin
                        ecall     = 1'b1;
                        epc       = pc_q;
                        csr_wdata = CAUSE_ECALL_M;
                    end else begin
                        mret = 1'b1;
                    end
                end
                ST_DONE: begin
                    out_valid   = 1'b1;
                    rd_data     = rd_q;
                    redirect    = redir_q;
                    redirect_pc = redir_pc_q;
                end
                default: begin
                    csr_id = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_seq.sv
// tb_csr_seq: randomized + directed bench for csr_seq with a transaction
// level reference model (latency table and CSR arithmetic). The bench also
// plays the CSR file: csr_rdata carries the old value only while csr_re is
// high and the trap vector only during ecall/mret/tint, junk otherwise.
// Build with CSR_SEQ_TINT_EN defined to exercise the interrupt path.
module tb_csr_seq;
    import csr_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [11:0] csr_addr = '0;
    logic [63:0] src = '0;
    logic        src_zero = 1'b0;
    logic [63:0] pc = '0;
    logic [63:0] resume_pc = '0;
    logic [11:0] csr_id;
    logic        csr_re;
    logic        csr_we;
    logic [63:0] csr_wdata;
    logic        ecall;
    logic        mret;
    logic [63:0] epc;
    logic [63:0] csr_rdata;
    logic        tint = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] rd_data;
    logic        redirect;
    logic [63:0] redirect_pc;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] cur_old = '0;
    logic [63:0] cur_vec = '0;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    always #5 clk = ~clk;

    csr_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .csr_addr(csr_addr), .src(src), .src_zero(src_zero),
        .pc(pc), .resume_pc(resume_pc), .csr_id(csr_id), .csr_re(csr_re),
        .csr_we(csr_we), .csr_wdata(csr_wdata), .ecall(ecall), .mret(mret),
        .epc(epc), .csr_rdata(csr_rdata), .tint(tint), .out_valid(out_valid),
        .out_ready(out_ready), .rd_data(rd_data), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    // CSR file stand-in: data is only meaningful in the cycle it should be sampled
    always_comb begin
        csr_rdata = JUNK;
        if (csr_re)                     csr_rdata = cur_old;
        else if (ecall || mret || tint) csr_rdata = cur_vec;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v;
    endfunction

    task automatic run_txn(input logic [2:0] o, input logic [11:0] a, input logic [63:0] s,
                           input logic sz, input logic [63:0] p, input logic [63:0] old_v,
                           input logic [63:0] vec_v, input int stall, input logic tint_v);
        int re_n, we_n, ec_n, mr_n, re_c, we_c, ec_c, mr_c, done_c, multi, unstable, exp_done;
        logic [63:0] we_d, ec_epc, ec_d, exp_wd, exp_rd;
        logic [11:0] re_id, we_id;
        logic rx, trap, exp_we;
        re_n = 0; we_n = 0; ec_n = 0; mr_n = 0;
        re_c = 0; we_c = 0; ec_c = 0; mr_c = 0;
        done_c = 0; multi = 0; unstable = 0;
        we_d = '0; ec_epc = '0; ec_d = '0; re_id = '0; we_id = '0;

        rx       = (o == OP_CSRRW) || (o == OP_CSRRS) || (o == OP_CSRRC);
        trap     = (o == OP_ECALL) || (o == OP_MRET);
        exp_done = rx ? 3 : (trap ? 2 : 1);
        exp_we   = rx && !((o != OP_CSRRW) && sz);
        exp_wd   = (o == OP_CSRRW) ? s : ((o == OP_CSRRS) ? (old_v | s) : (old_v & ~s));
        exp_rd   = rx ? old_v : 64'd0;

        cur_old  = old_v;
        cur_vec  = vec_v;
        op = o; csr_addr = a; src = s; src_zero = sz; pc = p; in_valid = 1'b1;
`ifdef CSR_SEQ_TINT_EN
        tint = 1'b0;
`else
        tint = tint_v;
`endif
        #1;
        check_eq("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        op = 3'($urandom); csr_addr = 12'($urandom); src = rnd64(); pc = rnd64();
        src_zero = ~sz;
        tint = tint_v;
        #1;
        for (int k = 1; k <= 8 && done_c == 0; k++) begin
            if (int'(csr_re) + int'(csr_we) + int'(ecall) + int'(mret) > 1) multi++;
            if (csr_re) begin re_n++; re_c = k; re_id = csr_id; end
            if (csr_we) begin we_n++; we_c = k; we_d = csr_wdata; we_id = csr_id; end
            if (ecall)  begin ec_n++; ec_c = k; ec_epc = epc; ec_d = csr_wdata; end
            if (mret)   begin mr_n++; mr_c = k; end
            if (out_valid) done_c = k;
            else tick();
        end
        tint = 1'b0;

        check_eq("done_latency", done_c, exp_done);
        check_eq("re_pulses", re_n, rx);
        if (rx) begin
            check_eq("re_cycle", re_c, 1);
            check_eq("re_id", re_id, a);
        end
        check_eq("we_pulses", we_n, exp_we);
        if (exp_we) begin
            check_eq("we_cycle", we_c, 2);
            check_eq("we_data", we_d, exp_wd);
            check_eq("we_id", we_id, a);
        end
        check_eq("ecall_pulses", ec_n, o == OP_ECALL);
        if (o == OP_ECALL) begin
            check_eq("ecall_cycle", ec_c, 1);
            check_eq("ecall_epc", ec_epc, p);
            check_eq("ecall_cause", ec_d, 64'd11);
        end
        check_eq("mret_pulses", mr_n, o == OP_MRET);
        if (o == OP_MRET) check_eq("mret_cycle", mr_c, 1);
        check_eq("strobe_overlap", multi, 0);

        check_eq("rd_data", rd_data, exp_rd);
        check_eq("redirect", redirect, trap);
        if (trap) check_eq("redirect_pc", redirect_pc, vec_v);

        out_ready = 1'b0;
        op = OP_CSRRW;
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            #1;
            if (out_valid !== 1'b1 || rd_data !== exp_rd || redirect !== trap ||
                (trap && redirect_pc !== vec_v) || in_ready !== 1'b0 || csr_id !== 12'd0 ||
                csr_re || csr_we || ecall || mret) unstable++;
            tick();
        end
        check_eq("done_stable", unstable, 0);

        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("back_to_idle", {out_valid, in_ready}, 2'b01);
    endtask

`ifdef CSR_SEQ_TINT_EN
    task automatic run_irq(input logic [63:0] rpc, input logic [63:0] vec_v);
        cur_vec   = vec_v;
        resume_pc = rpc;
        op        = OP_CSRRW;
        in_valid  = 1'b1;
        tint      = 1'b1;
        #1;
        check_eq("irq_in_ready", in_ready, 0);
        check_eq("irq_epc", epc, rpc);
        check_eq("irq_no_strobe", {csr_re, csr_we, ecall, mret}, 4'b0000);
        tick();
        tint     = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("irq_done", out_valid, 1);
        check_eq("irq_redirect", redirect, 1);
        check_eq("irq_redirect_pc", redirect_pc, vec_v);
        check_eq("irq_rd_data", rd_data, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check_eq("irq_back_idle", {out_valid, in_ready}, 2'b01);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  r_op;
        logic        r_sz;
        logic [63:0] r_src;

        rst = 1'b0;
        repeat (3) tick();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_strobes", {csr_re, csr_we, ecall, mret, redirect}, 5'b0);
        check_eq("rst_data", rd_data | redirect_pc | epc | csr_wdata, 0);
        rst = 1'b1;
        #1;
        check_eq("post_rst_ready", in_ready, 1);
        tick();

        run_txn(OP_CSRRS, 12'h300, 64'h8, 1'b0, 64'h100, 64'hA_0000_1800, 64'h0, 0, 1'b0);
        run_txn(OP_CSRRC, 12'h300, 64'h0, 1'b1, 64'h104, 64'h1234_5678_9ABC_DEF0, 64'h0, 1, 1'b0);
        run_txn(OP_CSRRW, 12'h341, 64'h0, 1'b1, 64'h108, 64'hFFFF_0000_FFFF_0000, 64'h0, 0, 1'b0);
        run_txn(OP_ECALL, 12'h000, 64'h0, 1'b0, 64'h8000_0010, 64'h0, 64'h8000_0100, 0, 1'b0);
        run_txn(OP_MRET,  12'h000, 64'h0, 1'b0, 64'h8000_0050, 64'h0, 64'h8000_0200, 2, 1'b0);
        run_txn(3'd0, 12'h305, 64'h55, 1'b0, 64'h200, 64'h77, 64'h99, 0, 1'b0);
        run_txn(3'd7, 12'h305, 64'h55, 1'b0, 64'h204, 64'h77, 64'h99, 1, 1'b0);
        run_txn(OP_CSRRW, 12'h342, 64'hCAFE_F00D_1234_5678, 1'b0, 64'h208,
                64'h1111_2222_3333_4444, 64'h0, 5, 1'b0);

`ifdef CSR_SEQ_TINT_EN
        run_irq(64'h8000_0020, 64'h8000_0100);
`else
        resume_pc = 64'h8000_0020;
        run_txn(OP_CSRRS, 12'h300, 64'h2, 1'b0, 64'h300, 64'h10, 64'h8000_0100, 0, 1'b1);
        tint = 1'b1;
        #1;
        check_eq("tint_off_epc", epc, 0);
        tint = 1'b0;
        tick();
`endif

        // reset landing on the WRITE cycle must swallow the write
        cur_old  = 64'h0F0F;
        op = OP_CSRRW; csr_addr = 12'h300; src = 64'hAAAA; src_zero = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        check_eq("pre_rst_we", csr_we, 1);
        rst = 1'b0;
        #1;
        check_eq("rst_kills_we", csr_we, 0);
        check_eq("rst_kills_ready", in_ready, 0);
        tick();
        check_eq("rst_hold_quiet", {out_valid, csr_re, csr_we, in_ready}, 4'b0);
        rst = 1'b1;
        #1;
        check_eq("rst_release_idle", in_ready, 1);
        tick();

        for (int i = 0; i < 40; i++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_sz  = ($urandom_range(0, 3) == 0);
            r_src = r_sz ? 64'd0 : rnd64();
`ifdef CSR_SEQ_TINT_EN
            if ($urandom_range(0, 4) == 0) run_irq(rnd64(), rnd64());
`endif
            run_txn(r_op, 12'($urandom), r_src, r_sz, rnd64(), rnd64(), rnd64(),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_seq.md
CSR_SEQ -- requirements
Module: csr_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on posedge.
REQ-002 SHALL have port: rst  input  1  synchronous active-low reset (0 = reset).
REQ-003 SHALL have ports: in_valid input 1, in_ready output 1  instruction handshake from decode.
REQ-004 SHALL have ports: op input 3 (1 CSRRW, 2 CSRRS, 3 CSRRC, 4 ECALL, 5 MRET, else illegal); csr_addr input 12; src input 64 (rs1 value or zero-extended uimm); src_zero input 1 (rs1 index/uimm == 0); pc input 64; resume_pc input 64 (next instruction address, for interrupts).
REQ-005 SHALL have CSR-file ports: csr_id output 12, csr_re output 1, csr_we output 1, csr_wdata output 64, ecall output 1, mret output 1, epc output 64, csr_rdata input 64, tint input 1.
REQ-006 SHALL have result ports: out_valid output 1, out_ready input 1, rd_data output 64, redirect output 1, redirect_pc output 64.

Function
REQ-007 SHALL implement FSM states IDLE, READ, WRITE, TRAP, DONE.
REQ-008 in_ready SHALL be 1 only in IDLE with no pending interrupt; accept = in_valid & in_ready; op, csr_addr, src, src_zero, pc SHALL be latched on accept.
REQ-009 CSRRW/RS/RC: IDLE -> READ -> WRITE -> DONE; accept cycle T, csr_re=1 at T+1 (old value latched), csr_we at T+2, out_valid at T+3.
REQ-010 New value: RW = src; RS = old | src; RC = old & ~src; full 64-bit, no truncation.
REQ-011 csr_we SHALL be suppressed in WRITE for RS/RC when src_zero=1; CSRRW always writes.
REQ-012 rd_data SHALL equal latched old value for CSRRx; redirect=0.
REQ-013 ECALL: IDLE -> TRAP -> DONE; in TRAP ecall=1, epc=latched pc, csr_wdata=64'd11, csr_rdata (mtvec) latched as redirect_pc; DONE redirect=1, rd_data=0.
REQ-014 MRET: IDLE -> TRAP -> DONE; in TRAP mret=1, csr_rdata (mepc) latched as redirect_pc; DONE redirect=1.
REQ-015 Illegal op: IDLE -> DONE directly, no CSR strobe, rd_data=0, redirect=0.
REQ-016 DONE SHALL hold out_valid and all result outputs stable until out_ready=1, then return to IDLE; no new accept in that same cycle.
REQ-017 csr_re, csr_we, ecall, mret SHALL be single-cycle pulses and mutually exclusive; csr_id = latched csr_addr in READ/WRITE, 0 otherwise.
REQ-018 Interrupt (when compiled in): tint=1 in IDLE SHALL take priority over in_valid in the same cycle; drive epc=resume_pc, latch csr_rdata (mtvec) as redirect_pc, go DONE with redirect=1; tint outside IDLE SHALL be ignored.

Reset
REQ-019 rst=0 at any clock edge SHALL force IDLE, drop an in-flight operation, and clear all strobes, out_valid, redirect, rd_data, redirect_pc, epc, csr_wdata to 0; in_ready=0 while rst=0.

Configuration
REQ-020 Macro CSR_SEQ_TINT_EN defined: REQ-018 active. Undefined: tint ignored, epc driven only in ECALL TRAP, interrupt path absent.

Structure
REQ-021 Package csr_seq_pkg SHALL hold op encodings, FSM state enum, cause constants (11; 64'h8000000000000007), CSR address constants.
REQ-022 Combinational sub-module csr_alu SHALL compute REQ-010 and the write-suppress flag of REQ-011.

Verification
REQ-023 CSRRS addr 0x300, old 0xA00001800, src 0x8 -> csr_re at T+1, csr_we at T+2 with wdata 0xA00001808, rd_data 0xA00001800 at T+3.
REQ-024 CSRRC src_zero=1 -> no csr_we pulse, rd_data = old value.
REQ-025 ECALL pc 0x80000010, mtvec 0x80000100 -> ecall pulse, epc 0x80000010, wdata 11, redirect=1, redirect_pc 0x80000100.
REQ-026 tint=1 with in_valid=1 in IDLE, resume_pc 0x80000020 -> in_ready=0, epc 0x80000020, redirect_pc = mtvec; macro off -> instruction accepted instead.
REQ-027 out_ready held 0 for 5 cycles in DONE -> outputs stable; rst=0 during WRITE -> no csr_we, IDLE next cycle.
